// File: rtl/reg_bank_executor.sv
// Register-bank executor: reads R[A]/R[B], runs the selected ALU op, writes R[Z].
// Optional EXEC_FLAGS_EN adds registered flag_zero/flag_carry outputs.
module reg_bank_executor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic [2:0]       Z,
  input  logic [3:0]       command,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`ifdef EXEC_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_carry
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t state, state_nxt;

  logic [7:0][WIDTH-1:0] regs;
  logic [2:0]            a_q, b_q, z_q;
  logic [3:0]            cmd_q;
  logic [WIDTH-1:0]      op_a, op_b;
  logic [WIDTH-1:0]      alu_res;
  logic                  legal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = READ;
      end
      READ:  state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
        done      = 1'b1;
        err       = ~legal;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU; shift amount is the full opB value, so large amounts saturate naturally
  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    case (cmd_q)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0010: alu_res = op_a & op_b;
      4'b0011: alu_res = op_a | op_b;
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = ~(op_a | op_b);
      4'b0110: alu_res = ~op_a;
      4'b0111: alu_res = op_a;
      4'b1010: alu_res = op_a << op_b;
      4'b1011: alu_res = op_a >> op_b;
      4'b1100: alu_res = $unsigned($signed(op_a) >>> op_b);
      default: legal   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= '0;
      cmd_q  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= A;
          b_q   <= B;
          z_q   <= Z;
          cmd_q <= command;
        end
        READ: begin
          op_a <= regs[a_q];
          op_b <= regs[b_q];
        end
        EXEC:    result <= legal ? alu_res : '0;
        default: ;
      endcase
    end
  end

  // Register file; write lands on the edge that ends WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= WIDTH'(i);
    end else if (state == WRITE && legal) begin
      regs[z_q] <= result;
    end
  end

  assign dbg_data = regs[dbg_addr];

`ifdef EXEC_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (state == EXEC) begin
      flag_zero  <= ~legal | (alu_res == '0);
      flag_carry <= (cmd_q == 4'b0000) ? sum_ext[WIDTH] :
                    (cmd_q == 4'b0001) ? (op_a < op_b) : 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_bank_executor.sv
// Directed bench for reg_bank_executor (WIDTH=8), hand-computed expectations.
module tb_reg_bank_executor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   A = '0, B = '0, Z = '0, dbg_addr = '0;
  logic [3:0]   command = '0;
  logic         done, err;
  logic [W-1:0] result, dbg_data;
`ifdef EXEC_FLAGS_EN
  logic         flag_zero, flag_carry;
`endif

  int pass_cnt = 0;
  int total    = 0;

  reg_bank_executor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Z(Z), .command(command), .done(done), .result(result),
    .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef EXEC_FLAGS_EN
    , .flag_zero(flag_zero), .flag_carry(flag_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one op, returns the cycle (1 = first after accept) in which done was seen.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] z,
                        input logic [3:0] cmd, output int cyc, output logic [W-1:0] res,
                        output logic er);
    @(negedge clk);
    A = a; B = b; Z = z; command = cmd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 10) cyc = -1;
    res = result;
    er  = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      total++;
      if (dbg_data !== W'(i)) $display("FAIL reset_reg[%0d] got %h exp %h", i, dbg_data, W'(i));
      else pass_cnt++;
    end
    total++;
    if (in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || result !== '0)
      $display("FAIL reset_outs got ready=%b done=%b err=%b result=%h exp 1 0 0 00",
               in_ready, done, err, result);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [3:0] ready_seen, done_seen;
    do_reset();
    @(negedge clk);
    A = 3'd2; B = 3'd3; Z = 3'd1; command = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      ready_seen[c-1] = in_ready;
      done_seen[c-1]  = done;
      if (c == 3) begin
        total++;
        if (result !== 8'd5) $display("FAIL add_result got %h exp 05", result);
        else pass_cnt++;
`ifdef EXEC_FLAGS_EN
        total++;
        if (flag_carry !== 1'b0 || flag_zero !== 1'b0)
          $display("FAIL add_flags got z=%b c=%b exp 0 0", flag_zero, flag_carry);
        else pass_cnt++;
`endif
      end
      if (c < 4) begin @(posedge clk); #1; end
    end
    total++;
    if (ready_seen !== 4'b1000) $display("FAIL add_ready got %b exp 1000", ready_seen);
    else pass_cnt++;
    total++;
    if (done_seen !== 4'b0100) $display("FAIL add_done_timing got %b exp 0100", done_seen);
    else pass_cnt++;
    dbg_addr = 3'd1; #1;
    total++;
    if (dbg_data !== 8'd5) $display("FAIL add_r1 got %h exp 05", dbg_data);
    else pass_cnt++;
  endtask

  task automatic test_sub();
    int cyc; logic [W-1:0] res; logic er;
    do_reset();
    run_op(3'd1, 3'd2, 3'd4, 4'b0001, cyc, res, er);
    total++;
    if (cyc !== 3 || res !== 8'hFF || er !== 1'b0)
      $display("FAIL sub got cyc=%0d res=%h err=%b exp 3 ff 0", cyc, res, er);
    else pass_cnt++;
    dbg_addr = 3'd4; #1;
    total++;
    if (dbg_data !== 8'hFF) $display("FAIL sub_r4 got %h exp ff", dbg_data);
    else pass_cnt++;
`ifdef EXEC_FLAGS_EN
    total++;
    if (flag_carry !== 1'b1 || flag_zero !== 1'b0)
      $display("FAIL sub_flags got z=%b c=%b exp 0 1", flag_zero, flag_carry);
    else pass_cnt++;
`endif
  endtask

  task automatic test_illegal();
    int dones, errs;
    do_reset();
    dones = 0; errs = 0;
    @(negedge clk);
    A = 3'd1; B = 3'd2; Z = 3'd6; command = 4'b1111; in_valid = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (done && err) errs++;
      if (e == 2) begin
        total++;
        if (result !== '0) $display("FAIL illegal_result got %h exp 00", result);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 1 || errs !== 1) $display("FAIL illegal_pulses got done=%0d err=%0d exp 1 1", dones, errs);
    else pass_cnt++;
    dbg_addr = 3'd6; #1;
    total++;
    if (dbg_data !== 8'd6 || in_ready !== 1'b1)
      $display("FAIL illegal_nowrite got r6=%h ready=%b exp 06 1", dbg_data, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_shifts();
    int cyc; logic [W-1:0] res; logic er;
    logic [2:0]   ta [5];
    logic [2:0]   tb [5];
    logic [2:0]   tz [5];
    logic [3:0]   tc [5];
    logic [W-1:0] te [5];
    // R7=1<<3; R2=5>>8; R3=8<<4; R0=80>>>1; R4=80>>>8
    ta = '{3'd1, 3'd5, 3'd7, 3'd3, 3'd3};
    tb = '{3'd3, 3'd7, 3'd4, 3'd1, 3'd7};
    tz = '{3'd7, 3'd2, 3'd3, 3'd0, 3'd4};
    tc = '{4'b1010, 4'b1011, 4'b1010, 4'b1100, 4'b1100};
    te = '{8'h08, 8'h00, 8'h80, 8'hC0, 8'hFF};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tz[i], tc[i], cyc, res, er);
      dbg_addr = tz[i]; #1;
      total++;
      if (cyc !== 3 || res !== te[i] || er !== 1'b0 || dbg_data !== te[i])
        $display("FAIL shift[%0d] got cyc=%0d res=%h err=%b reg=%h exp 3 %h 0 %h",
                 i, cyc, res, er, dbg_data, te[i], te[i]);
      else pass_cnt++;
`ifdef EXEC_FLAGS_EN
      total++;
      if (flag_zero !== (te[i] == 8'h00) || flag_carry !== 1'b0)
        $display("FAIL shift_flags[%0d] got z=%b c=%b", i, flag_zero, flag_carry);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_logic_ops();
    int cyc; logic [W-1:0] res; logic er;
    logic [2:0]   ta [7];
    logic [2:0]   tb [7];
    logic [2:0]   tz [7];
    logic [3:0]   tc [7];
    logic [W-1:0] te [7];
    // Last entry writes Z==A==B: operands must come from pre-write state
    ta = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd5, 3'd7, 3'd2};
    tb = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd2};
    tz = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
    tc = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0000};
    te = '{8'h02, 8'h07, 8'h05, 8'hF8, 8'hFA, 8'h07, 8'h04};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], tz[i], tc[i], cyc, res, er);
      dbg_addr = tz[i]; #1;
      total++;
      if (res !== te[i] || er !== 1'b0 || dbg_data !== te[i])
        $display("FAIL op[%0d] got res=%h err=%b reg=%h exp %h 0 %h",
                 i, res, er, dbg_data, te[i], te[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    do_reset();
    dones = 0;
    @(negedge clk);
    A = 3'd2; B = 3'd3; Z = 3'd5; command = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    dbg_addr = 3'd5; #1;
    total++;
    if (dones !== 0 || dbg_data !== 8'd5 || in_ready !== 1'b1)
      $display("FAIL reset_mid_op got dones=%0d r5=%h ready=%b exp 0 05 1", dones, dbg_data, in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_shifts();
    test_logic_ops();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
